// File: rtl/mips_defs.sv
// Shared encodings for the memory arbiter: FSM states, owner IDs and starvation default.
package mips_defs;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam int STARVE_LIMIT_DEF = 3;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive fetch losses under contention; o_force asks the arbiter to let fetch win.
// Only present when MEM_ARB_STARVE_GUARD_EN is defined.
`ifdef MEM_ARB_STARVE_GUARD_EN
module arb_starve_ctr
   import mips_defs::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sample,
   input  logic i_if_req,
   input  logic i_d_req,
   output logic o_force
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   assign o_force = (r_cnt == CW'(LIMIT));

   // Fetch idle, fetch alone, or a forced fetch win all restart the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_sample) begin
         if (!i_if_req || !i_d_req || o_force) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for one shared single-cycle memory; 2-cycle latency.
// Data wins ties; MEM_ARB_STARVE_GUARD_EN adds a starvation guard that periodically forces fetch.
module mem_arbiter
   import mips_defs::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [1:0]        r_state;
   logic              r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic w_sample;
   logic w_issue;
   logic w_resp;
   logic w_force_if;
   logic w_d_wins;

   if (STARVE_LIMIT < 1) begin : g_limit_chk
      $error("mem_arbiter: STARVE_LIMIT must be at least 1");
   end

   assign w_issue  = (r_state == ST_ISSUE);
   assign w_resp   = (r_state == ST_RESP);
   assign w_sample = !w_issue;

`ifdef MEM_ARB_STARVE_GUARD_EN
   arb_starve_ctr #(
      .LIMIT    (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk      (clk),
      .rst      (rst),
      .i_sample (w_sample),
      .i_if_req (if_req),
      .i_d_req  (d_req),
      .o_force  (w_force_if)
   );
`else
   assign w_force_if = 1'b0;
`endif

   assign w_d_wins = d_req && !(if_req && w_force_if);

   // Requests are only looked at outside ISSUE; RESP doubles as the next sample slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_IF;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (!w_sample) begin
         r_state <= ST_RESP;
      end else if (if_req || d_req) begin
         r_state <= ST_ISSUE;
         if (w_d_wins) begin
            r_owner <= OWN_D;
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
         end else begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= if_addr;
            r_wdata <= '0;
         end
      end else begin
         r_state <= ST_IDLE;
      end
   end

   assign if_gnt    = w_issue && (r_owner == OWN_IF);
   assign d_gnt     = w_issue && (r_owner == OWN_D);
   assign if_valid  = w_resp && (r_owner == OWN_IF);
   assign d_valid   = w_resp && (r_owner == OWN_D);
   assign if_rdata  = if_valid ? mem_rdata : '0;
   assign d_rdata   = (d_valid && !r_we) ? mem_rdata : '0;

   assign mem_en    = w_issue;
   assign mem_we    = w_issue && r_we;
   assign mem_addr  = w_issue ? r_addr : '0;
   assign mem_wdata = w_issue ? r_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle plus literal spot checks.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          if_gnt, if_valid, d_gnt, d_valid;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Read-only memory image; writes are accepted but do not change it.
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h4) return 32'h8C02_0000;
      return a ^ 32'h5A5A_0000;
   endfunction

   // Junk outside the response cycle so ungated rdata shows up.
   always @(posedge clk)
      mem_rdata <= (mem_en && !mem_we) ? memf(mem_addr) : 32'hBAD0_BAD0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Transaction model: an "in issue" slot and an "in response" slot.
   logic          m_iss_v = 0, m_rsp_v = 0;
   int            m_iss_own, m_rsp_own;
   logic          m_iss_we, m_rsp_we;
   logic [31:0]   m_iss_addr, m_rsp_addr, m_iss_wd;
   int            m_starve = 0;
   bit            m_free, m_dwin;

   always @(posedge clk) begin
      if (rst) begin
         m_iss_v = 0; m_rsp_v = 0; m_starve = 0;
      end else begin
         m_free     = !m_iss_v;
         m_rsp_v    = m_iss_v;
         m_rsp_own  = m_iss_own;
         m_rsp_we   = m_iss_we;
         m_rsp_addr = m_iss_addr;
         m_iss_v    = 0;
         if (m_free && (if_req || d_req)) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            m_dwin = d_req && !(if_req && m_starve >= LIM);
`else
            m_dwin = d_req;
`endif
            m_iss_v = 1;
            if (m_dwin) begin
               m_iss_own = 1; m_iss_we = d_we; m_iss_addr = d_addr; m_iss_wd = d_wdata;
            end else begin
               m_iss_own = 0; m_iss_we = 0; m_iss_addr = if_addr; m_iss_wd = 0;
            end
         end
         if (m_free) begin
            if (if_req && d_req && m_dwin) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            else m_starve = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("if_gnt",    if_gnt,    m_iss_v && m_iss_own == 0);
         chk("d_gnt",     d_gnt,     m_iss_v && m_iss_own == 1);
         chk("if_valid",  if_valid,  m_rsp_v && m_rsp_own == 0);
         chk("d_valid",   d_valid,   m_rsp_v && m_rsp_own == 1);
         chk("if_rdata",  if_rdata,  (m_rsp_v && m_rsp_own == 0) ? memf(m_rsp_addr) : 32'h0);
         chk("d_rdata",   d_rdata,   (m_rsp_v && m_rsp_own == 1 && !m_rsp_we) ? memf(m_rsp_addr) : 32'h0);
         chk("mem_en",    mem_en,    m_iss_v);
         chk("mem_we",    mem_we,    m_iss_v && m_iss_we);
         chk("mem_addr",  mem_addr,  m_iss_v ? m_iss_addr : 32'h0);
         chk("mem_wdata", mem_wdata, m_iss_v ? m_iss_wd : 32'h0);
         chk("two_gnts",  if_gnt && d_gnt, 0);
         chk("gnt_valid_owners", (if_gnt && d_valid) || (d_gnt && if_valid), 0);
      end
   end

   int gq[$];
   always @(negedge clk) begin
      if (if_gnt) gq.push_back(0);
      else if (d_gnt) gq.push_back(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] en_bits, vl_bits;
   logic [0:7] exp_ord;
   logic       saw_if_gnt;

   initial begin
      rst = 1; if_req = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0;

      // Reset
      tick();
      chk_en = 1;
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_valids", {if_valid, d_valid}, 0);
      chk("rst_gnts", {if_gnt, d_gnt}, 0);
      tick();
      rst = 0;

      // Lone fetch
      if_req = 1; if_addr = 32'h4;
      tick();
      @(negedge clk);
      chk("fetch_gnt", if_gnt, 1);
      chk("fetch_mem_addr", mem_addr, 32'h4);
      chk("fetch_mem_en", mem_en, 1);
      tick();
      if_req = 0;
      @(negedge clk);
      chk("fetch_valid", if_valid, 1);
      chk("fetch_rdata", if_rdata, 32'h8C02_0000);
      tick();

      // Store
      d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
      tick();
      @(negedge clk);
      chk("store_mem_we", mem_we, 1);
      chk("store_mem_addr", mem_addr, 32'h10);
      chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      d_req = 0; d_we = 0;
      @(negedge clk);
      chk("store_valid", d_valid, 1);
      chk("store_rdata", d_rdata, 0);
      tick();

      // Back-to-back loads
      d_req = 1; d_addr = 32'h20;
      en_bits = '0; vl_bits = '0;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 2) d_addr = 32'h24;
         if (c == 4) d_addr = 32'h28;
         if (c == 6) d_req = 0;
         @(negedge clk);
         en_bits[c] = mem_en;
         vl_bits[c] = d_valid;
      end
      chk("b2b_mem_en_cycles", en_bits, 8'b0010_1010);
      chk("b2b_d_valid_cycles", vl_bits, 8'b0101_0100);
      tick();

      // Contention, both held for eight grants
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_ord = 8'b1110_1110;
`else
      exp_ord = 8'b1111_1111;
`endif
      gq.delete();
      if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
      repeat (16) tick();
      if_req = 0; d_req = 0;
      tick(); tick();
      chk("contention_count", gq.size(), 8);
      for (int k = 0; k < 8; k++) chk("contention_order", gq[k], exp_ord[k]);

      // Reset during ISSUE of a load
      d_req = 1; d_addr = 32'h30;
      tick();
      rst = 1; d_req = 0;
      @(negedge clk);
      chk("rst_mid_gnt_before", d_gnt, 1);
      tick();
      rst = 0;
      @(negedge clk);
      chk("rst_mid_no_valid", {if_valid, d_valid}, 0);
      chk("rst_mid_mem_en", mem_en, 0);
      chk("rst_mid_rdata", d_rdata, 0);
      d_req = 1; d_addr = 32'h34;
      tick();
      @(negedge clk);
      chk("post_rst_gnt", d_gnt, 1);
      chk("post_rst_addr", mem_addr, 32'h34);
      tick();
      d_req = 0;
      @(negedge clk);
      chk("post_rst_valid", d_valid, 1);
      chk("post_rst_rdata", d_rdata, 32'h5A5A_0034);
      tick();

      // Fetch pulse during a data ISSUE is ignored
      d_req = 1; d_addr = 32'h50;
      tick();
      if_req = 1; if_addr = 32'h60;
      saw_if_gnt = 0;
      tick();
      if_req = 0; d_req = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         saw_if_gnt = saw_if_gnt | if_gnt;
         tick();
      end
      chk("withdraw_no_if_gnt", saw_if_gnt, 0);

      // Random traffic with occasional reset, checked by the model
      for (int c = 0; c < 400; c++) begin
         if_req  = ($urandom_range(0, 3) != 0);
         d_req   = ($urandom_range(0, 2) != 0);
         d_we    = $urandom_range(0, 1) != 0;
         if_addr = 32'($urandom_range(0, 255)) << 2;
         d_addr  = 32'($urandom_range(0, 255)) << 2;
         d_wdata = $urandom;
         rst     = ($urandom_range(0, 49) == 0);
         tick();
      end
      rst = 0; if_req = 0; d_req = 0;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, byte address width. DATA_W, 32, data width. STARVE_LIMIT, 3, consecutive fetch losses before fetch is forced.
REQ-002 The clock and reset SHALL be a single clock and a synchronous, active-high reset, as listed below.
REQ-003 Ports SHALL be (name direction width meaning):
- clk input 1 clock; all logic on rising edge
- rst input 1 synchronous active-high reset
- if_req input 1 instruction-fetch request
- if_addr input ADDR_W fetch address (PC)
- if_gnt output 1 fetch request accepted (1-cycle pulse)
- if_valid output 1 fetch read data valid (1-cycle pulse)
- if_rdata output DATA_W fetch instruction word
- d_req input 1 data request
- d_we input 1 data write enable (1 = store, 0 = load)
- d_addr input ADDR_W data address (ALU result)
- d_wdata input DATA_W store data
- d_gnt output 1 data request accepted (1-cycle pulse)
- d_valid output 1 load data valid / store done (1-cycle pulse)
- d_rdata output DATA_W load data
- mem_en output 1 shared memory access strobe
- mem_we output 1 shared memory write enable
- mem_addr output ADDR_W shared memory address
- mem_wdata output DATA_W shared memory write data
- mem_rdata input DATA_W shared memory read data, valid the cycle after mem_en

Function
REQ-004 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-005 In IDLE or RESP, if any request is high at the clock edge, the arbiter SHALL register the winner, address, we and wdata, then enter ISSUE; otherwise it SHALL enter IDLE.
REQ-006 In ISSUE, mem_en SHALL be 1 with the registered values, and the winner's gnt SHALL be 1; the next state SHALL be RESP.
REQ-007 In RESP, the winner's valid SHALL be 1 and its rdata SHALL equal mem_rdata for a read, or 0 for a write.
REQ-008 Outside ISSUE, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-009 Latency SHALL be 2 cycles from the sampling edge to valid; back-to-back throughput SHALL be one access per 2 cycles (RESP overlaps the next sample).
REQ-010 Priority SHALL go to data over fetch when both requests are high, subject to REQ-012.
REQ-011 A requester SHALL hold req, addr, we and wdata stable until its gnt; the arbiter SHALL ignore changes after sampling; dropping req before sampling withdraws the request.
REQ-012 The starvation counter SHALL increment (saturating at STARVE_LIMIT) on each sample where both requests are high and data wins, SHALL clear on each fetch win or whenever if_req is low at a sample, and when it equals STARVE_LIMIT fetch SHALL win.
REQ-013 At any time, at most one gnt and at most one valid SHALL be high, and they SHALL never belong to different owners in the same cycle.
REQ-014 Fetch SHALL never write to memory; mem_we SHALL be 0 whenever fetch is the owner.

Reset
REQ-015 On rst, the state SHALL be IDLE, every output SHALL be 0 and the counter SHALL be 0 at the next edge.
REQ-016 Reset during ISSUE or RESP SHALL abandon the transaction, and no valid SHALL be produced for it.

Configuration
REQ-017 With MEM_ARB_STARVE_GUARD_EN defined, REQ-012 SHALL apply.
REQ-018 Without MEM_ARB_STARVE_GUARD_EN, priority SHALL be strict data-over-fetch, and the counter logic SHALL be absent.

Structure
REQ-019 The shared package/header mips_defs SHALL hold the state encodings (IDLE, ISSUE, RESP), the owner IDs (OWN_IF = 0, OWN_D = 1) and the STARVE_LIMIT default.
REQ-020 The counter SHALL be the sub-module arb_starve_ctr, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-021 Lone fetch: if_req = 1 and if_addr = 0x00000004 sampled at edge 0, memory returns 0x8C020000 -> if_gnt and mem_en with mem_addr = 0x4 at cycle 1; if_valid with if_rdata = 0x8C020000 at cycle 2.
REQ-022 Store: d_req = 1, d_we = 1, d_addr = 0x10, d_wdata = 0xDEADBEEF -> cycle 1 has mem_we = 1 with those values; cycle 2 has d_valid = 1 and d_rdata = 0.
REQ-023 Contention with guard on and both requests held with STARVE_LIMIT = 3 -> grant order D, D, D, IF, D, D, D, IF; with guard off -> D continuously and if_gnt never asserted.
REQ-024 Back-to-back: d_req held over 3 loads at addresses 0x20, 0x24 and 0x28 -> mem_en pulses on cycles 1, 3 and 5, and d_valid on cycles 2, 4 and 6.
REQ-025 Reset mid-operation: rst = 1 in the ISSUE cycle of a load -> the next cycle has all outputs 0 and no d_valid, the state is IDLE, and a new request is served normally.
REQ-026 Withdrawal: if_req pulses high for 1 cycle while the arbiter is in ISSUE for data -> no if_gnt is issued.
